// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - launch/result bundle between execute stage and muldiv_unit
interface muldiv_unit_if;
    logic        start;
    logic        flush;
    logic [2:0]  md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] md_data;

    modport master (
        output start, flush, md_op, op_a, op_b,
        input  busy, done, md_data
    );

    modport slave (
        input  start, flush, md_op, op_a, op_b,
        output busy, done, md_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide, 32 steps per op, fast path for div corner cases
module muldiv_unit (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_hi_rem;
    logic        r_neg;
    logic [31:0] r_opnd;
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_md_data;

    logic        w_sa, w_sb, w_a_sgn, w_b_sgn, w_neg;
    logic [31:0] w_mag_a, w_mag_b;
    logic        w_bzero, w_ovf, w_fast;
    logic [31:0] w_fast_res;

    assign w_sa = bus.op_a[31];
    assign w_sb = bus.op_b[31];

    always_comb begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
        w_neg   = 1'b0;
        case (bus.md_op)
            OP_MULH:   begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; w_neg = w_sa ^ w_sb; end
            OP_MULHSU: begin w_a_sgn = 1'b1; w_neg = w_sa; end
            OP_DIV:    begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; w_neg = w_sa ^ w_sb; end
            OP_REM:    begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; w_neg = w_sa; end
            default:   ;
        endcase
    end

    assign w_mag_a = (w_a_sgn && w_sa) ? -bus.op_a : bus.op_a;
    assign w_mag_b = (w_b_sgn && w_sb) ? -bus.op_b : bus.op_b;

    // Signed overflow only applies to DIV/REM (md_op[0]==0 within the divide group)
    assign w_bzero    = (bus.op_b == 32'd0);
    assign w_ovf      = !bus.md_op[0] && (bus.op_a == 32'h8000_0000) && (bus.op_b == 32'hFFFF_FFFF);
    assign w_fast     = bus.md_op[2] && (w_bzero || w_ovf);
    assign w_fast_res = w_bzero ? (bus.md_op[1] ? bus.op_a : 32'hFFFF_FFFF)
                                : (bus.md_op[1] ? 32'd0    : 32'h8000_0000);

    logic [32:0] w_sum;
    logic [63:0] w_prod_nx;
    logic [32:0] w_shift;
    logic        w_fits;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quot_nx;

    assign w_sum     = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_prod_nx = {w_sum, r_prod[31:1]};

    // Remainder stays below the divisor, so the 32-bit wrapped difference is exact
    assign w_shift   = {r_rem, r_quot[31]};
    assign w_fits    = (w_shift >= {1'b0, r_opnd});
    assign w_rem_nx  = w_fits ? (w_shift[31:0] - r_opnd) : w_shift[31:0];
    assign w_quot_nx = {r_quot[30:0], w_fits};

    logic [63:0] w_prod_fix;
    logic [31:0] w_q_fix, w_r_fix, w_calc_res;

    assign w_prod_fix = r_neg ? -w_prod_nx : w_prod_nx;
    assign w_q_fix    = r_neg ? -w_quot_nx : w_quot_nx;
    assign w_r_fix    = r_neg ? -w_rem_nx  : w_rem_nx;
    assign w_calc_res = r_is_div ? (r_hi_rem ? w_r_fix : w_q_fix)
                                 : (r_hi_rem ? w_prod_fix[63:32] : w_prod_fix[31:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_is_div  <= 1'b0;
            r_hi_rem  <= 1'b0;
            r_neg     <= 1'b0;
            r_opnd    <= 32'd0;
            r_prod    <= 64'd0;
            r_rem     <= 32'd0;
            r_quot    <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_md_data <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (bus.start) begin
                            r_cnt    <= 5'd0;
                            r_is_div <= bus.md_op[2];
                            r_hi_rem <= bus.md_op[2] ? bus.md_op[1] : |bus.md_op[1:0];
                            r_neg    <= w_neg;
                            r_opnd   <= bus.md_op[2] ? w_mag_b : w_mag_a;
                            r_prod   <= {32'd0, w_mag_b};
                            r_rem    <= 32'd0;
                            r_quot   <= w_mag_a;
                            if (w_fast) begin
                                r_md_data <= w_fast_res;
                                r_done    <= 1'b1;
                                r_state   <= S_DONE;
                            end else begin
                                r_busy  <= 1'b1;
                                r_state <= S_CALC;
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_CALC: begin
                        r_prod <= w_prod_nx;
                        r_rem  <= w_rem_nx;
                        r_quot <= w_quot_nx;
                        r_cnt  <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_md_data <= w_calc_res;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.md_data = r_md_data;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage. Opcodes that cannot complete in the single-cycle ALU are launched here. The unit holds the hazard logic in stall for a fixed 32-cycle computation and returns one 32-bit result with a done pulse. Divide-by-zero and signed-overflow cases use a one-cycle fast path.

## Interface
- No parameters; data width fixed at 32 bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  launch request; sampled only in IDLE or DONE
- flush  input  1  abort; discards any operation in flight
- md_op  input  3  funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  32  rs1 operand (multiplicand / dividend)
- op_b  input  32  rs2 operand (multiplier / divisor)
- busy  output  1  high in CALC; drives pipeline stall
- done  output  1  one-cycle pulse; md_data valid
- md_data  output  32  result; held until next accepted start

## Operation
- States: IDLE, CALC, DONE.
- Accepting start (state IDLE or DONE, start=1, flush=0):
  - latch md_op and operand magnitudes;
  - latch result-sign flags:
    - MULH: sign(a)^sign(b)
    - MULHSU: sign(a)
    - DIV: sign(a)^sign(b)
    - REM: sign(a)
  - unsigned variants use raw operands, no sign fix;
  - clear the 5-bit iteration counter; go to CALC.
- Fast path, checked at accept, goes directly to DONE:
  - DIV/DIVU with op_b=0: quotient 0xFFFFFFFF.
  - REM/REMU with op_b=0: remainder = op_a.
  - DIV with op_a=0x80000000, op_b=0xFFFFFFFF: quotient 0x80000000.
  - REM with op_a=0x80000000, op_b=0xFFFFFFFF: remainder 0.
- CALC multiply: shift-add, one multiplier bit per cycle into a 64-bit accumulator.
  - MUL returns low 32 bits; MULH* return high 32 bits.
  - Negate the 64-bit product before selecting the half if the sign flag is set.
- CALC divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
  - Negate quotient or remainder at completion per its sign flag.
- Counter reaches 31 in CALC: register md_data, go to DONE.
- DONE lasts one cycle with done=1.
  - start=1 in DONE: accepted, back-to-back.
  - start=0 in DONE: go to IDLE.
- start while in CALC: ignored, no queuing.
- flush=1: next state IDLE from any state, no done, md_data unchanged; flush has priority over start.
- Reset values: state IDLE, busy 0, done 0, md_data 0x00000000, counter 0.
- Reset asserted mid-operation: immediate return to reset values; no done.

## Timing
- Start sampled at edge E0.
- Normal op:
  - busy high from E0 to E32;
  - DONE entered at E32; done high in the cycle after E32;
  - 33-cycle latency from accept to done.
- Fast path: DONE entered at E0; busy never rises; done high in the cycle after E0.
- done and busy never high together.
- md_data changes only at the edge that enters DONE.
- Operands and md_op may change after E0 without effect.

## Test plan
- Reset, then MUL op_a=7, op_b=0xFFFFFFFD:
  - busy high for 32 cycles;
  - done in the 33rd cycle after accept;
  - md_data=0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000*0x80000000 -> 0x40000000;
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV -7/2 -> 0xFFFFFFFD;
  - REM -7/2 -> 0xFFFFFFFF;
  - DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF;
  - REMU 0xFFFFFFFF/0x10 -> 0xF.
- Fast path, each with done one cycle after accept and busy never high:
  - DIV 5/0 -> 0xFFFFFFFF;
  - REMU 5/0 -> 5;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
  - REM same operands -> 0.
- Control:
  - start pulsed while in CALC: ignored.
  - flush at iteration 10: IDLE next cycle, no done, md_data keeps the prior result.
  - rst asserted mid-CALC: all outputs 0 immediately.
- Back-to-back: start held high through DONE with a second MUL 3*4; second done 33 cycles later with md_data=0x0000000C.
